btn_debounce_bank: RTL
======================

BTN_DEBOUNCE_BANK -- requirements
Module: btn_debounce_bank

Interface
REQ-001 Parameter N_CH, default 5: number of independent button channels (1..32).
REQ-002 Parameter DB_CYCLES, default 262144: consecutive disagreeing cycles required before a debounced level changes (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50000000: cycles a debounced press must persist before long-press is flagged (>=1).
REQ-004 Parameter REPEAT_CYCLES, default 10000000: auto-repeat period while held; 0 disables periodic repeat.
REQ-005 Parameter INVERT, default {N_CH{1'b0}}: per-channel mask; 1 = input is active-low.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_in  input  N_CH  raw asynchronous button levels.
REQ-009 btn_db  output  N_CH  debounced pressed level (1 = pressed, after INVERT).
REQ-010 btn_rise  output  N_CH  one-cycle pulse on debounced press.
REQ-011 btn_fall  output  N_CH  one-cycle pulse on debounced release.
REQ-012 btn_hold  output  N_CH  level; 1 while a press has lasted >= HOLD_CYCLES.
REQ-013 btn_rep  output  N_CH  one-cycle auto-repeat pulse.

Function
REQ-014 Each channel SHALL apply INVERT, then a 2-FF synchronizer; all channels fully independent, no shared counters.
REQ-015 Debounce counter width SHALL be $clog2(DB_CYCLES+1); counter clears on any cycle where synchronized level equals btn_db.
REQ-016 On a mismatch cycle with counter == DB_CYCLES-1, btn_db SHALL take the synchronized level and counter clears; otherwise counter increments.
REQ-017 Latency: btn_in stable from sampling edge k SHALL change btn_db at edge k+1+DB_CYCLES.
REQ-018 A glitch shorter than DB_CYCLES synchronized cycles SHALL leave btn_db, rise, fall unchanged.
REQ-019 btn_rise/btn_fall SHALL be registered, asserted exactly on the edge btn_db changes 0->1 / 1->0, high one cycle.
REQ-020 Hold counter SHALL clear while btn_db=0, count while btn_db=1, saturate at HOLD_CYCLES (no wrap).
REQ-021 btn_hold SHALL assert on the edge HOLD_CYCLES cycles after btn_rise and deassert on the same edge btn_fall pulses.
REQ-022 btn_rep SHALL pulse on the edge btn_hold asserts, then every REPEAT_CYCLES cycles while btn_hold=1; single pulse only if REPEAT_CYCLES=0.
REQ-023 Repeat counter SHALL clear when btn_hold=0; a release coincident with a due repeat SHALL suppress that btn_rep pulse.
REQ-024 Per-channel state machine: IDLE -> PRESSED (btn_rise) -> HELD (btn_hold) -> IDLE (btn_fall); PRESSED -> IDLE on btn_fall.
REQ-025 All outputs SHALL be registered; no combinational path from btn_in to any output.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear synchronizers, all counters, btn_db, btn_rise, btn_fall, btn_hold, btn_rep to 0.
REQ-027 Reset deassertion SHALL be synchronized to clk before use by all state.
REQ-028 Reset mid-press: after release of rst_n, a still-pressed channel SHALL re-debounce from released state and pulse btn_rise after full latency.

Verification (N_CH=2, DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, INVERT=2'b10)
REQ-029 ch0 btn_in 0->1 at edge 10, held -> btn_db[0]=1 and btn_rise[0] pulse at edge 15; no change on ch1.
REQ-030 ch0 3-cycle high glitch -> btn_db, btn_rise, btn_fall stay 0; 4-cycle hold -> rise.
REQ-031 ch0 held 40 cycles after rise -> btn_hold at rise+20, btn_rep pulses at rise+20, +28, +36; release -> btn_fall, btn_hold=0 same edge, no further rep.
REQ-032 ch1 (inverted) btn_in 1->0 -> btn_db[1]=1 after 5 edges; ch0 and ch1 pressed simultaneously -> simultaneous, independent rise pulses.
REQ-033 rst_n pulsed low mid-hold (ch0 held) -> all outputs 0 immediately; after release btn_rise[0] reappears after 5+sync edges, hold restarts from 0.
REQ-034 Bounce train toggling every 2 cycles for 30 cycles then settling high -> exactly one btn_rise, zero btn_fall.

Source files
------------

// File: rtl/btn_debounce_bank.sv
// Bank of independent push-button conditioners: synchronise, debounce, edge-detect,
// long-press detect and auto-repeat, one fully separate pipeline per channel.
module btn_debounce_bank #(
    parameter int              N_CH          = 5,
    parameter int              DB_CYCLES     = 262144,
    parameter int              HOLD_CYCLES   = 50000000,
    parameter int              REPEAT_CYCLES = 10000000,
    parameter logic [N_CH-1:0] INVERT        = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_db,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_hold,
    output logic [N_CH-1:0] btn_rep
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam bit REP_EN = (REPEAT_CYCLES > 0);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HELD
    } state_e;

    // Reset asserts asynchronously but releases two clocks later, so every
    // flop below leaves reset on the same edge.
    logic [1:0] rst_pipe_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe_q <= 2'b00;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            rst_pipe_q <= {rst_pipe_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe_q[1];

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [1:0]        sync_q;
        logic              level;
        logic              db_q;
        logic              rise_q;
        logic              fall_q;
        logic              hold_q;
        logic              rep_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic [HOLD_W-1:0] hold_cnt_q;
        logic [REP_W-1:0]  rep_cnt_q;
        state_e            state_q;
        state_e            state_d;

        logic mismatch;
        logic db_flip;
        logic rise_ev;
        logic fall_ev;
        logic hold_set;
        logic rep_due;
        logic rep_ev;

        // Polarity is normalised before the synchroniser so everything
        // downstream sees 1 = pressed.
        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], btn_in[ch] ^ INVERT[ch]};
            end
        end

        assign level = sync_q[1];

        always_comb begin
            mismatch = (level != db_q);
            db_flip  = mismatch && (db_cnt_q == DB_LAST);
            rise_ev  = db_flip && level;
            fall_ev  = db_flip && !level;
            // A release landing on the same edge wins over a long-press.
            hold_set = db_q && !fall_ev && (hold_cnt_q == HOLD_LAST);
            rep_due  = REP_EN && hold_q && (rep_cnt_q == REP_LAST);
        end

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                db_cnt_q <= '0;
                db_q     <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                db_cnt_q <= (!mismatch || db_flip) ? '0 : db_cnt_q + 1'b1;
                db_q     <= db_flip ? level : db_q;
                rise_q   <= rise_ev;
                fall_q   <= fall_ev;
            end
        end

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                hold_cnt_q <= '0;
            end else if (!db_q || fall_ev) begin
                hold_cnt_q <= '0;
            end else if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            // NOTE: every combinational output gets a default first so no path
            // through the case leaves it unassigned and infers a latch.
            state_d = state_q;
            case (state_q)
                S_IDLE: begin
                    if (rise_ev) state_d = S_PRESSED;
                end
                S_PRESSED: begin
                    if (fall_ev)       state_d = S_IDLE;
                    else if (hold_set) state_d = S_HELD;
                end
                S_HELD: begin
                    if (fall_ev) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            rep_ev = ((state_q == S_PRESSED) && (state_d == S_HELD)) ||
                     (rep_due && !fall_ev);
        end

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                hold_q    <= 1'b0;
                rep_q     <= 1'b0;
                rep_cnt_q <= '0;
            end else begin
                hold_q <= (state_d == S_HELD);
                rep_q  <= rep_ev;
                // Repeat phase restarts each time the long-press is entered.
                if (!hold_q || rep_due) begin
                    rep_cnt_q <= '0;
                end else begin
                    rep_cnt_q <= rep_cnt_q + 1'b1;
                end
            end
        end

        assign btn_db[ch]   = db_q;
        assign btn_rise[ch] = rise_q;
        assign btn_fall[ch] = fall_q;
        assign btn_hold[ch] = hold_q;
        assign btn_rep[ch]  = rep_q;
    end

endmodule
